// File: rtl/bufferram_out_pkg.sv
// Shared constants and FSM encoding for the output buffer RAM read-side streamer.
package bufferram_out_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 16;
    localparam int NUM_WORDS = 96000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bufferram_out_fifo.sv
// Small synchronous skid FIFO; occupancy count feeds the streamer's read credit.
module bufferram_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bufferram_out_streamer.sv
// Reads a programmed window of halfwords from the buffer RAM read port and streams them out.
module bufferram_out_streamer
    import bufferram_out_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] length,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [1:0]        ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, len_q, len_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              loop_q, loop_d, inflight_q, inflight_d, last_q, last_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_empty, issue, abort, push;
    logic [ADDR_W-1:0] base_norm, addr_next;

    assign base_norm   = (base >= ADDR_W'(NUM_WORDS)) ? base - ADDR_W'(NUM_WORDS) : base;
    assign addr_next   = (addr_q == ADDR_W'(NUM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
    assign abort       = stop && (state_q != ST_IDLE);
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = (state_q == ST_FETCH) && !stop && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    // A read return is dropped in the cycle a stop lands; the FIFO is flushed on that same edge.
    assign push        = inflight_q && !abort;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_d      = base_q;
        len_d       = len_q;
        loop_d      = loop_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        last_d      = issue && (remaining_q == ADDR_W'(1));
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    base_d      = base_norm;
                    len_d       = length;
                    loop_d      = loop;
                    addr_d      = base_norm;
                    remaining_d = length;
                    if (length == '0) done_d  = 1'b1;
                    else              state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d      = addr_next;
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) begin
                        if (loop_q) begin
                            addr_d      = base_q;
                            remaining_d = len_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                if (push && last_q && loop_q) done_d = 1'b1;
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            inflight_d = 1'b0;
            last_d     = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            last_q      <= last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Stream handshake: a word moves on any rising edge where out_valid & out_ready;
    // out_valid never drops and out_data never changes until that word has moved.
    bufferram_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (push),
        .push_data (ram_readdata),
        .pop       (out_ready),
        .head_data (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid      = !fifo_empty;
    assign ram_address    = addr_q;
    assign ram_chipselect = issue;
    assign ram_write      = 1'b0;
    assign ram_byteenable = 2'b11;
    assign ram_writedata  = '0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/bufferram_out_streamer.md
Name: bufferram_out_streamer

Overview:
- Read-side engine for the dual-clock output buffer RAM. Drives the 16-bit, 96000-word port of the buffer on a single clock and streams a programmed window of halfwords out as an Avalon-ST source.
- The CPU fills the buffer through the 32-bit port. It then pulses start with a base address and length. This block fetches the words, absorbs the RAM's 1-cycle read latency and downstream backpressure, and reports completion.

Parameters:
- ADDR_W, 17, RAM halfword address width
- DATA_W, 16, RAM/stream data width
- NUM_WORDS, 96000, RAM depth in halfwords; addresses wrap from NUM_WORDS-1 to 0
- FIFO_DEPTH, 4, output skid FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock; also drives the RAM read-port clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; latch base/length/loop and begin; ignored while busy
- stop  in  1  1-cycle pulse; abort the current transfer
- base  in  ADDR_W  first halfword address
- length  in  ADDR_W  halfwords per pass (0 allowed)
- loop  in  1  1 = repeat the window until stop
- busy  out  1  high from the cycle after an accepted start until IDLE is re-entered
- done  out  1  1-cycle pulse at end of a pass (each pass when looping) or after an abort
- ram_address  out  ADDR_W  to RAM port-B address
- ram_chipselect  out  1  to RAM port-B chipselect
- ram_write  out  1  tied 0
- ram_byteenable  out  2  tied 2'b11
- ram_writedata  out  DATA_W  tied 0
- ram_readdata  in  DATA_W  from RAM port B; valid 1 cycle after chipselect with address
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; transfer occurs when valid & ready

Behaviour:
- Reset values:
  - busy=0, done=0, ram_chipselect=0, ram_address=0, out_valid=0.
  - FIFO empty, FSM in IDLE, all counters 0.
- FSM states:
  - IDLE: start=1 -> latch inputs. If length==0, pulse done next cycle and stay IDLE (busy stays 0). Otherwise go to FETCH, set addr=base and remaining=length.
  - FETCH: issue one read per cycle while occupancy+inflight < FIFO_DEPTH.
    - Each issue: addr advances by 1 with wrap at NUM_WORDS; remaining decrements.
    - When the last read of a pass issues: if loop=1, reload addr=base and remaining=length, and pulse done when that pass's final word enters the FIFO. If loop=0, go to DRAIN.
  - DRAIN: wait for inflight=0 and FIFO empty, then pulse done and go to IDLE.
  - stop in FETCH/DRAIN: cease issuing and drop any in-flight read return. Flush the FIFO the next cycle, pulse done, go to IDLE.
  - Same-cycle start and stop in IDLE: stop wins and start is ignored.
- Read path:
  - ram_chipselect is asserted combinationally with ram_address in the issue cycle.
  - ram_readdata is captured into the FIFO exactly 1 cycle later (inflight is a 1-bit flag).
  - No reads are issued when the FIFO could overflow, so out_ready may deassert at any time without data loss.
- Stream rules:
  - out_data/out_valid come from the FIFO head. out_data must hold stable while out_valid=1 and out_ready=0.
  - Order is strictly address order.
  - Best-case latency: start at cycle 0, read issued at cycle 1, out_valid at cycle 3.
  - With out_ready held at 1, sustained throughput is 1 word/cycle.
- Arithmetic: address increment is modulo NUM_WORDS, not 2^ADDR_W. base >= NUM_WORDS is treated as base-NUM_WORDS.
- Reset asserted mid-transfer: everything returns to reset values immediately; no done pulse.

Decomposition:
- Shared package bufferram_out_pkg holds:
  - ADDR_W, DATA_W, NUM_WORDS constants.
  - FSM state enum (IDLE, FETCH, DRAIN).
- Sub-module bufferram_out_fifo: synchronous FIFO with async active-low reset, a flush input, and an occupancy count output. The streamer uses it for credit computation.

Test Plan:
- base=100, length=4, out_ready=1 -> RAM holding addr n = n returns out_data 100,101,102,103 on consecutive cycles; one done pulse; busy falls after done.
- base=95998, length=4 -> stream 95998, 95999, 0, 1 (wrap at NUM_WORDS).
- length=64, out_ready toggled 1 cycle on / 3 off -> all 64 words delivered in order, none lost or duplicated; FIFO occupancy never exceeds 4.
- length=0 start -> done pulse the next cycle, ram_chipselect never asserted, out_valid stays 0.
- loop=1, base=10, length=3 -> stream 10,11,12,10,11,12,… with done after each 12. Then stop -> out_valid=0 within 2 cycles, one done pulse, IDLE.
- reset_n pulsed low mid-FETCH with the FIFO holding 2 words -> out_valid=0, busy=0, done=0 immediately. A subsequent start with base=0, length=2 streams 0,1 cleanly.
